// File: rtl/iq_pack_pkg.sv
// Shared constants, state encoding and helpers for the I/Q sample packer.
package iq_pack_pkg;

  localparam logic [15:0] HDR_MAGIC     = 16'hA55A;
  localparam int          HDR_MAGIC_LSB = 48;
  localparam int          HDR_FRAME_LSB = 32;
  localparam int          HDR_OVF_LSB   = 16;
  localparam int          HDR_SKEW_BIT  = 0;
  localparam int          CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Frame header: magic, frame number, drop count, zero pad, sticky skew flag.
  function automatic logic [63:0] buildHeader(input logic [CNT_W-1:0] frame,
                                              input logic [CNT_W-1:0] ovf,
                                              input logic             skew);
    logic [63:0] hdr;
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: 16]    = HDR_MAGIC;
    hdr[HDR_FRAME_LSB +: CNT_W] = frame;
    hdr[HDR_OVF_LSB +: CNT_W]   = ovf;
    hdr[HDR_SKEW_BIT]           = skew;
    return hdr;
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/iq_pair_aligner.sv
// Pairs independent I and Q strobes through one-entry hold registers with a
// shared skew timer; a half-pair older than SKEW_MAX cycles is discarded.
module iq_pair_aligner
  import iq_pack_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SKEW_MAX = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_active,
  input  logic                  i_clrErr,
  input  logic [DATA_W-1:0]     i_iData,
  input  logic                  i_iValid,
  input  logic [DATA_W-1:0]     i_qData,
  input  logic                  i_qValid,
  output logic                  o_pairValid,
  output logic [2*DATA_W-1:0]   o_pairData,
  output logic                  o_skewErr
);

  localparam int               AGE_W    = $clog2(SKEW_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(SKEW_MAX - 1);

  logic [DATA_W-1:0] r_iHold;
  logic [DATA_W-1:0] r_qHold;
  logic              r_iFull;
  logic              r_qFull;
  logic [AGE_W-1:0]  r_age;
  logic              r_skewErr;

  logic              w_pair;
  logic              w_overwrite;
  logic              w_timeout;
  logic [DATA_W-1:0] w_iSel;
  logic [DATA_W-1:0] w_qSel;

  // A fresh strobe always wins over the held copy of the same channel.
  always_comb begin
    w_iSel      = i_iValid ? i_iData : r_iHold;
    w_qSel      = i_qValid ? i_qData : r_qHold;
    w_pair      = i_active & (i_iValid | r_iFull) & (i_qValid | r_qFull);
    w_overwrite = i_active & ((i_iValid & r_iFull) | (i_qValid & r_qFull));
    w_timeout   = i_active & ~i_iValid & ~i_qValid & (r_iFull | r_qFull) &
                  (r_age == AGE_LAST);
  end

  assign o_pairValid = w_pair;
  assign o_pairData  = {w_iSel, w_qSel};
  assign o_skewErr   = r_skewErr;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_iHold   <= '0;
      r_qHold   <= '0;
      r_iFull   <= 1'b0;
      r_qFull   <= 1'b0;
      r_age     <= '0;
      r_skewErr <= 1'b0;
    end else begin
      if (i_clrErr) begin
        r_skewErr <= 1'b0;
      end else if (w_overwrite | w_timeout) begin
        r_skewErr <= 1'b1;
      end

      if (!i_active || w_pair || w_timeout) begin
        r_iFull <= 1'b0;
        r_qFull <= 1'b0;
        r_age   <= '0;
      end else begin
        if (i_iValid) begin
          r_iFull <= 1'b1;
          r_iHold <= i_iData;
        end
        if (i_qValid) begin
          r_qFull <= 1'b1;
          r_qHold <= i_qData;
        end
        if (i_iValid | i_qValid) begin
          r_age <= '0;
        end else if (r_iFull | r_qFull) begin
          r_age <= r_age + AGE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/iq_sample_packer.sv
// Frames aligned I/Q pairs into 64-bit FIFO words behind a header per block.
// Optional build macro IQ_PACK_TESTPAT_EN adds tp_en and a ramp test pattern.
module iq_sample_packer
  import iq_pack_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int WRCNT_W     = 11,
  parameter int FULL_THRESH = 2040,
  parameter int BLOCKSIZE   = 1024,
  parameter int SKEW_MAX    = 8
) (
  input  logic                clk,
  input  logic                arstn,
  input  logic                enable,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_valid,
  input  logic [DATA_W-1:0]   q_data,
  input  logic                q_valid,
`ifdef IQ_PACK_TESTPAT_EN
  input  logic                tp_en,
`endif
  input  logic [WRCNT_W-1:0]  fifo_wrcnt,
  output logic [2*DATA_W-1:0] fifo_data,
  output logic                fifo_we,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    overflow_cnt,
  output logic                skew_err,
  output logic                busy
);

  localparam int                 PCNT_W    = $clog2(BLOCKSIZE + 1);
  localparam logic [PCNT_W-1:0]  PAIR_LAST = PCNT_W'(BLOCKSIZE - 1);
  localparam logic [WRCNT_W-1:0] THRESH    = WRCNT_W'(FULL_THRESH);

  state_t              r_state;
  logic                r_enPrev;
  logic                r_pendValid;
  logic [2*DATA_W-1:0] r_pend;
  logic [PCNT_W-1:0]   r_pairCnt;
  logic [CNT_W-1:0]    r_frameCnt;
  logic [CNT_W-1:0]    r_ovfCnt;
  logic [2*DATA_W-1:0] r_fifoData;
  logic                r_fifoWe;

  logic                w_enRise;
  logic                w_run;
  logic                w_space;
  logic                w_pairValid;
  logic [2*DATA_W-1:0] w_pairData;
  logic                w_skewErr;
  logic                w_pairWr;
  logic [2*DATA_W-1:0] w_rawData;
  logic [2*DATA_W-1:0] w_wrData;
  logic [2*DATA_W-1:0] w_hdr;

  assign w_enRise  = enable & ~r_enPrev;
  assign w_run     = enable & (r_state != IDLE);
  assign w_space   = fifo_wrcnt < THRESH;
  assign w_pairWr  = w_run & (r_state == STREAM) & (r_pendValid | w_pairValid) & w_space;
  assign w_rawData = r_pendValid ? r_pend : w_pairData;
  assign w_hdr     = (2*DATA_W)'(buildHeader(r_frameCnt, r_ovfCnt, w_skewErr));

  iq_pair_aligner #(
    .DATA_W   (DATA_W),
    .SKEW_MAX (SKEW_MAX)
  ) u_aligner (
    .clk         (clk),
    .arstn       (arstn),
    .i_active    (w_run),
    .i_clrErr    (w_enRise),
    .i_iData     (i_data),
    .i_iValid    (i_valid),
    .i_qData     (q_data),
    .i_qValid    (q_valid),
    .o_pairValid (w_pairValid),
    .o_pairData  (w_pairData),
    .o_skewErr   (w_skewErr)
  );

`ifdef IQ_PACK_TESTPAT_EN
  logic [DATA_W-1:0] r_ramp;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_ramp <= '0;
    end else if (w_enRise) begin
      r_ramp <= '0;
    end else if (w_pairWr) begin
      r_ramp <= r_ramp + DATA_W'(1);
    end
  end

  assign w_wrData = tp_en ? {r_ramp, ~r_ramp} : w_rawData;
`else
  assign w_wrData = w_rawData;
`endif

  // The pending register only fills when a pair collides with a header write
  // or with an older pending pair being drained in the same cycle.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state     <= IDLE;
      r_enPrev    <= 1'b0;
      r_pendValid <= 1'b0;
      r_pend      <= '0;
      r_pairCnt   <= '0;
      r_frameCnt  <= '0;
      r_ovfCnt    <= '0;
      r_fifoData  <= '0;
      r_fifoWe    <= 1'b0;
    end else begin
      r_enPrev <= enable;
      r_fifoWe <= 1'b0;
      if (!enable) begin
        r_state     <= IDLE;
        r_pendValid <= 1'b0;
        r_pairCnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_enRise) begin
              r_state   <= HDR;
              r_pairCnt <= '0;
            end
          end
          HDR: begin
            if (w_space) begin
              r_fifoWe   <= 1'b1;
              r_fifoData <= w_hdr;
              r_frameCnt <= r_frameCnt + CNT_W'(1);
              r_state    <= STREAM;
              if (w_pairValid) begin
                if (r_pendValid) begin
                  r_ovfCnt <= satInc(r_ovfCnt);
                end else begin
                  r_pendValid <= 1'b1;
                  r_pend      <= w_pairData;
                end
              end
            end else if (w_pairValid) begin
              r_ovfCnt <= satInc(r_ovfCnt);
            end
          end
          STREAM: begin
            if (w_pairWr) begin
              r_fifoWe   <= 1'b1;
              r_fifoData <= w_wrData;
              if (r_pairCnt == PAIR_LAST) begin
                r_pairCnt <= '0;
                r_state   <= HDR;
              end else begin
                r_pairCnt <= r_pairCnt + PCNT_W'(1);
              end
            end else if (r_pendValid | w_pairValid) begin
              r_ovfCnt <= satInc(r_ovfCnt);
            end
            if (r_pendValid & w_pairValid) begin
              r_pend <= w_pairData;
            end
            r_pendValid <= r_pendValid & w_pairValid;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign fifo_data    = r_fifoData;
  assign fifo_we      = r_fifoWe;
  assign frame_cnt    = r_frameCnt;
  assign overflow_cnt = r_ovfCnt;
  assign skew_err     = w_skewErr;
  assign busy         = (r_state != IDLE);

endmodule
